latch_write_sched: RTL and testbench
====================================

LATCH_WRITE_SCHED -- requirements
Module: latch_write_sched

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared latch.
REQ-002 Parameter NREQ, default 4, number of requesters.
REQ-003 Parameter HOLD, default 2, cycles lat_en stays high per write; legal range 1..15, 0 illegal.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester write request, level; held until matching ack.
REQ-007 wdata  input  NREQ*WIDTH  per-requester write data, slice i belongs to req[i].
REQ-008 gnt  output  NREQ  one-hot grant, registered.
REQ-009 ack  output  NREQ  one-cycle completion pulse to the winner, registered.
REQ-010 lat_en  output  1  enable for the shared level-sensitive latch, registered.
REQ-011 lat_d  output  WIDTH  data presented to the shared latch, registered.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states IDLE, SETUP, OPEN, CLOSE, ACK; exactly one active per cycle.
REQ-014 IDLE: if any req bit high, select winner round-robin, capture its wdata into lat_d, set gnt[winner], go to SETUP; else stay IDLE.
REQ-015 Round-robin: search starts at (last_winner+1) mod NREQ, wrapping; last_winner updated on entry to ACK.
REQ-016 SETUP: one cycle, lat_en=0, lat_d stable, then OPEN.
REQ-017 OPEN: lat_en=1 for exactly HOLD cycles (down-counter loaded with HOLD-1), then CLOSE.
REQ-018 CLOSE: one cycle, lat_en=0, lat_d still stable (hold margin), then ACK.
REQ-019 ACK: one cycle, gnt=0, ack[winner]=1, then IDLE.
REQ-020 gnt stays asserted for SETUP, OPEN and CLOSE only.
REQ-021 Latency: req sampled high in IDLE cycle n -> gnt from n+1, lat_en high n+2..n+1+HOLD, ack at n+3+HOLD.
REQ-022 Throughput: back-to-back writes every HOLD+4 cycles (ACK->IDLE->SETUP).
REQ-023 lat_d changes only on IDLE->SETUP; wdata changes after capture are ignored.
REQ-024 req deasserted mid-transaction: transaction still completes and ack still pulses.
REQ-025 req still high in IDLE after its ack is treated as a new request, arbitrated fairly with others.
REQ-026 Simultaneous requests: exactly one granted; others wait, no request lost.
REQ-027 lat_en and gnt never high in IDLE or ACK; lat_d never changes while lat_en=1.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, gnt=0, ack=0, lat_en=0, lat_d=0, busy=0, counter=0.
REQ-029 Reset value of last_winner is NREQ-1, so requester 0 has priority on first arbitration.
REQ-030 Reset mid-transaction aborts it with no ack; after release the requester re-arbitrates if req still high.

Structure
REQ-031 Shared package holds the state enumeration and the HOLD counter width constant (4 bits).
REQ-032 One sub-module rr_pick: combinational round-robin picker (req, last_winner -> one-hot winner, valid).
REQ-033 All outputs driven from flip-flops; no combinational path from req/wdata to any output.

Verification
REQ-034 Single: req=4'b0001, wdata[0]=8'hA5, reset released -> gnt=0001 next cycle, lat_d=A5, lat_en high 2 cycles, ack[0] at request cycle+5.
REQ-035 Contention: req=4'b1111 held, distinct data -> grants 0,1,2,3,0 each 6 cycles apart; ack order matches.
REQ-036 Data change: wdata[2] 8'h11->8'h22 one cycle after gnt[2] -> lat_d stays 11 through ACK.
REQ-037 Drop: req[1] deasserted during OPEN -> lat_en completes HOLD cycles, ack[1] still pulses once.
REQ-038 Reset mid-OPEN: reset_n low -> lat_en, gnt, lat_d, busy go 0 immediately, no ack; after release, req[3] high -> granted afresh from requester 0 priority.
REQ-039 HOLD=1 build: single request -> lat_en high exactly 1 cycle, ack at request cycle+4.

Source files
------------

// File: rtl/latch_write_sched_pkg.sv
// Shared types and constants for the latch write scheduler.
//   state_e : scheduler FSM states
//   CNT_W   : width of the lat_en hold down-counter (HOLD is 1..15)
//   idx_w   : width of a requester index for n requesters
package latch_write_sched_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_OPEN  = 3'd2,
        ST_CLOSE = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    // Index width for n requesters, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latch_write_sched_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   last_i   : index of the previous winner; search starts one above it
//   valid_c  : at least one request present
//   onehot_c : one-hot winner
//   idx_c    : binary index of the winner
module rr_pick
    import latch_write_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_c,
    output logic [NREQ-1:0]  onehot_c,
    output logic [IDX_W-1:0] idx_c
);

    // Walk the requesters from last_i+1, wrapping; the first hit wins.
    always_comb begin
        int unsigned pos;
        valid_c  = 1'b0;
        onehot_c = '0;
        idx_c    = '0;
        pos      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = (32'(last_i) + k) % NREQ;
            if (!valid_c && req_i[IDX_W'(pos)]) begin
                valid_c                  = 1'b1;
                onehot_c[IDX_W'(pos)]    = 1'b1;
                idx_c                    = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/latch_write_sched.sv
// Schedules writes from NREQ requesters into one shared level-sensitive latch.
// Each write runs SETUP (data stable, enable low), OPEN (enable high for HOLD
// cycles), CLOSE (enable low, data still stable) and ACK (one-cycle ack pulse).
//   clock, reset_n : clock, asynchronous active-low reset
//   req            : per-requester level request, held until ack
//   wdata          : per-requester write data, slice i belongs to req[i]
//   gnt            : one-hot grant during SETUP/OPEN/CLOSE
//   ack            : one-cycle completion pulse to the winner
//   lat_en, lat_d  : enable and data for the shared latch
//   busy           : high whenever the scheduler is not idle
// HOLD must lie in 1..15.
module latch_write_sched
    import latch_write_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned HOLD  = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  lat_en,
    output logic [WIDTH-1:0]      lat_d,
    output logic                  busy
);

    localparam int unsigned IDX_W = idx_w(NREQ);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               lat_en_q, lat_en_d;
    logic [WIDTH-1:0]   lat_d_q, lat_d_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [NREQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   wdata_arr [NREQ];

    // Unpack the flat data bus into per-requester words.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign wdata_arr[g] = wdata[g*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .last_i   (last_q),
        .valid_c  (pick_valid),
        .onehot_c (pick_onehot),
        .idx_c    (pick_idx)
    );

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            gnt_q    <= '0;
            ack_q    <= '0;
            lat_en_q <= 1'b0;
            lat_d_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            lat_en_q <= lat_en_d;
            lat_d_q  <= lat_d_d;
            busy_q   <= busy_d;
        end
    end

    // Next state; outputs are computed for the state being entered so that
    // every output comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        lat_en_d = 1'b0;
        lat_d_d  = lat_d_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    win_d   = pick_idx;
                    gnt_d   = pick_onehot;
                    lat_d_d = wdata_arr[pick_idx];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d    = CNT_W'(HOLD - 1);
                lat_en_d = 1'b1;
                state_d  = ST_OPEN;
            end
            ST_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = ST_CLOSE;
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    lat_en_d = 1'b1;
                end
            end
            ST_CLOSE: begin
                // Entering ACK: drop the grant, pulse ack, remember the winner.
                gnt_d        = '0;
                ack_d[win_q] = 1'b1;
                last_d       = win_q;
                state_d      = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign lat_en = lat_en_q;
    assign lat_d  = lat_d_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_latch_write_sched.sv
// Bench for latch_write_sched: directed scenarios plus random traffic, checked
// by a transaction-timeline model feeding an expected-transaction queue.
module tb_latch_write_sched;

    localparam int W = 8;
    localparam int N = 4;
    localparam int H = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wdata;
    logic [N-1:0]     gnt, ack;
    logic             lat_en, busy;
    logic [W-1:0]     lat_d;

    logic [N-1:0]     req1;
    logic [N*W-1:0]   wdata1;
    logic [N-1:0]     gnt1, ack1;
    logic             lat_en1, busy1;
    logic [W-1:0]     lat_d1;

    always #5 clock = ~clock;

    latch_write_sched #(.WIDTH(W), .NREQ(N), .HOLD(H)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .lat_en(lat_en), .lat_d(lat_d), .busy(busy));

    latch_write_sched #(.WIDTH(W), .NREQ(N), .HOLD(1)) dut_h1 (
        .clock(clock), .reset_n(reset_n), .req(req1), .wdata(wdata1),
        .gnt(gnt1), .ack(ack1), .lat_en(lat_en1), .lat_d(lat_d1), .busy(busy1));

    typedef struct {
        int           win;
        logic [W-1:0] data;
        int           g;   // first cycle with gnt high
        int           a;   // ack cycle
    } txn_t;

    typedef struct {
        int           win;
        int           c;
        logic [W-1:0] d;
    } ack_t;

    txn_t         exq[$];
    ack_t         alog[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    int           last_m, free_m, mw, mg, ma;
    logic [W-1:0] exp_latd;
    bit           pend [N];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lw(input int i);
        return (i < alog.size()) ? alog[i].win : -1;
    endfunction
    function automatic int lc(input int i);
        return (i < alog.size()) ? alog[i].c : -1;
    endfunction
    function automatic int ld(input int i);
        return (i < alog.size()) ? int'(alog[i].d) : -1;
    endfunction

    // Transaction model: an idle scheduler that sees any request in cycle n
    // serves the next requester round-robin; grant from n+1, ack at n+3+H,
    // and it is free to arbitrate again at n+H+4.
    task automatic model_step();
        int   w;
        txn_t t;
        w = -1;
        if (cyc >= free_m && req != '0) begin
            for (int k = 1; k <= N; k++)
                if (w < 0 && req[(last_m + k) % N]) w = (last_m + k) % N;
            t.win  = w;
            t.data = wdata[w*W +: W];
            t.g    = cyc + 1;
            t.a    = cyc + 3 + H;
            exq.push_back(t);
            last_m = w;
            free_m = cyc + H + 4;
            mw = w; mg = t.g; ma = t.a;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("reset_state", 64'({gnt, ack, lat_en, busy, lat_d}), 64'd0);
        exq.delete();
        last_m = N - 1; exp_latd = '0; mw = -1; mg = -1; ma = -1;
        repeat (2) begin @(posedge clock); #1; end
        reset_n = 1'b1;
        free_m = cyc;
    endtask

    // Monitor: derive expected outputs from the front transaction, pop it
    // when its ack cycle arrives, and log every ack the DUT presents.
    always @(negedge clock) begin
        logic [N-1:0]   e_gnt, e_ack;
        logic           e_en, e_busy;
        logic [W-1:0]   e_d;
        txn_t           t;
        if (mon_en && reset_n) begin
            e_gnt = '0; e_ack = '0; e_en = 1'b0; e_busy = 1'b0; e_d = exp_latd;
            if (exq.size() > 0 && cyc >= exq[0].g) begin
                t      = exq[0];
                e_d    = t.data;
                e_busy = 1'b1;
                if (cyc <= t.a - 1) e_gnt[t.win] = 1'b1;
                if (cyc >= t.g + 1 && cyc <= t.g + H) e_en = 1'b1;
                if (cyc == t.a) begin
                    e_ack[t.win] = 1'b1;
                    exp_latd = t.data;
                    void'(exq.pop_front());
                end
            end
            check("outputs{gnt,ack,en,busy,d}", 64'({gnt, ack, lat_en, busy, lat_d}),
                  64'({e_gnt, e_ack, e_en, e_busy, e_d}));
            for (int i = 0; i < N; i++)
                if (ack[i]) alog.push_back('{win: i, c: cyc, d: lat_d});
        end
    end

    initial begin
        int base, n0, en_cnt, ack_off, h1_gnt;
        logic [W-1:0] d_ack;

        reset_n = 1'b1; req = '0; wdata = '0; req1 = '0; wdata1 = '0;
        last_m = N - 1; free_m = 0; mw = -1; mg = -1; ma = -1; exp_latd = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        @(posedge clock); #1;
        do_reset();
        mon_en = 1'b1;

        // Single write from requester 0.
        wdata[7:0] = 8'hA5; req = 4'b0001; base = alog.size(); n0 = cyc;
        repeat (6) step();
        req = '0; repeat (4) step();
        check("single_cnt", 64'(alog.size() - base), 64'd1);
        check("single_win", 64'(lw(base)), 64'd0);
        check("single_lat", 64'(lc(base) - n0), 64'd5);
        check("single_data", 64'(ld(base)), 64'hA5);

        // Contention from a fresh reset: 0,1,2,3,0 six cycles apart.
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111; base = alog.size(); n0 = cyc;
        repeat (30) step();
        req = '0; repeat (4) step();
        check("cont_cnt", 64'(alog.size() - base), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check("cont_win", 64'(lw(base + k)), 64'(k % 4));
            check("cont_lat", 64'(lc(base + k) - n0), 64'(5 + 6 * k));
        end

        // Data change after capture is ignored.
        wdata[23:16] = 8'h11; req = 4'b0100; base = alog.size();
        step(); step();
        wdata[23:16] = 8'h22;
        repeat (4) step();
        req = '0; repeat (4) step();
        check("dchg_win", 64'(lw(base)), 64'd2);
        check("dchg_data", 64'(ld(base)), 64'h11);

        // Request dropped during OPEN still completes once.
        wdata[15:8] = 8'h5C; req = 4'b0010; base = alog.size(); n0 = cyc;
        step(); step();
        req = '0;
        repeat (8) step();
        check("drop_cnt", 64'(alog.size() - base), 64'd1);
        check("drop_win", 64'(lw(base)), 64'd1);
        check("drop_lat", 64'(lc(base) - n0), 64'd5);

        // Reset in the middle of OPEN aborts; requester 3 then wins afresh.
        wdata[7:0] = 8'h5A; req = 4'b0001;
        step(); step();
        check("pre_reset_en", 64'(lat_en), 64'd1);
        req = 4'b1000; wdata[31:24] = 8'hC3; base = alog.size();
        do_reset();
        n0 = cyc;
        repeat (6) step();
        req = '0; repeat (4) step();
        check("rst_cnt", 64'(alog.size() - base), 64'd1);
        check("rst_win", 64'(lw(base)), 64'd3);
        check("rst_lat", 64'(lc(base) - n0), 64'd5);
        check("rst_data", 64'(ld(base)), 64'hC3);

        // Random traffic: hold until ack, occasional drops, re-requests, data churn.
        for (int it = 0; it < 1500; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1; req[i] = 1'b1;
                        wdata[i*W +: W] = W'($urandom);
                    end
                end else if (i == mw && cyc == ma) begin
                    if ($urandom_range(0, 1) == 0) begin
                        wdata[i*W +: W] = W'($urandom);
                    end else begin
                        pend[i] = 1'b0; req[i] = 1'b0;
                    end
                end else if (i == mw && cyc > mg && cyc < ma && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0; req[i] = 1'b0;
                end
                if (pend[i] && $urandom_range(0, 7) == 0) wdata[i*W +: W] = W'($urandom);
            end
            step();
        end
        req = '0;
        repeat (12) step();
        check("drain", 64'(exq.size()), 64'd0);

        // HOLD=1 instance: one enable cycle, ack four cycles after the request.
        do_reset();
        wdata1[7:0] = 8'h77; req1 = 4'b0001; n0 = cyc;
        en_cnt = 0; ack_off = -1; h1_gnt = 0; d_ack = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (lat_en1) en_cnt++;
            if (cyc - n0 == 1) h1_gnt = int'(gnt1);
            if (ack1[0] && ack_off < 0) begin
                ack_off = cyc - n0;
                d_ack = lat_d1;
            end
        end
        req1 = '0;
        @(posedge clock); #1;
        check("h1_gnt", 64'(h1_gnt), 64'd1);
        check("h1_en_cycles", 64'(en_cnt), 64'd1);
        check("h1_ack_lat", 64'(ack_off), 64'd4);
        check("h1_data", 64'(d_ack), 64'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
